// File: rtl/vec_act_quant_pipe.sv
// Multi-lane activation + affine quantization pipeline: 4 register stages with a global stall.
// Define LEAKY_RELU_EN to build the leaky ReLU path for act_mode 3 (otherwise mode 3 acts as ReLU).
module vec_act_quant_pipe #(
  parameter int LANES     = 4,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 8,
  parameter int FRAC_BITS = 8,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  input  logic [1:0]             act_mode,
  input  logic [ACC_W-1:0]       clip_max,
  input  logic [4:0]             leak_shift,
  input  logic [15:0]            inv_scale,
  input  logic [OUT_W-1:0]       zero_point,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       sat_flags,
  output logic [CNT_W-1:0]       sat_count,
  input  logic                   sat_clear
);

  localparam int PW = ACC_W + 16;
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [PW-1:0] Q_MAX      = (PW'(1) <<< (OUT_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] Q_MIN      = -(PW'(1) <<< (OUT_W - 1));
  localparam logic [CNT_W:0]       CNT_MAX    = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_CLIP  = 2'd2,
    MODE_LEAKY = 2'd3
  } act_mode_e;

  logic                    w_stall;
  act_mode_e               w_mode;
  logic signed [ACC_W-1:0] w_clip;
  logic signed [ACC_W-1:0] w_x [LANES];
  logic signed [ACC_W-1:0] w_y [LANES];

  logic                    r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
  logic signed [ACC_W-1:0] r_s1_y [LANES];
  logic signed [15:0]      r_s1_inv;
  logic signed [OUT_W-1:0] r_s1_zp, r_s2_zp, r_s3_zp;
  logic signed [PW-1:0]    r_s2_p [LANES];
  logic signed [PW-1:0]    r_s3_r [LANES];

  logic signed [PW-1:0]    w_b [LANES];
  logic [LANES*OUT_W-1:0]  w_q;
  logic [LANES-1:0]        w_sat;

  logic [LANES*OUT_W-1:0]  r_out_data;
  logic [LANES-1:0]        r_sat_flags;
  logic [CNT_W-1:0]        r_sat_count;
  logic [CNT_W:0]          w_pop, w_sum;

  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign sat_flags = r_sat_flags;
  assign sat_count = r_sat_count;

  assign w_mode = act_mode_e'(act_mode);
  assign w_clip = $signed(clip_max);

`ifndef LEAKY_RELU_EN
  logic w_unused_leak;
  assign w_unused_leak = ^leak_shift;
`endif

  // Activation is evaluated on the live config so the beat captures it at acceptance.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_x[l] = $signed(in_data[l*ACC_W +: ACC_W]);
      w_y[l] = w_x[l];
      case (w_mode)
        MODE_PASS: w_y[l] = w_x[l];
        MODE_RELU: w_y[l] = w_x[l][ACC_W-1] ? '0 : w_x[l];
        MODE_CLIP: begin
          if (w_clip[ACC_W-1] || w_x[l][ACC_W-1]) w_y[l] = '0;
          else if (w_x[l] > w_clip)                 w_y[l] = w_clip;
          else                                      w_y[l] = w_x[l];
        end
        MODE_LEAKY: begin
`ifdef LEAKY_RELU_EN
          w_y[l] = w_x[l][ACC_W-1] ? (w_x[l] >>> leak_shift) : w_x[l];
`else
          w_y[l] = w_x[l][ACC_W-1] ? '0 : w_x[l];
`endif
        end
        default: w_y[l] = w_x[l];
      endcase
    end
  end

  always_comb begin
    w_q   = '0;
    w_sat = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_b[l] = r_s3_r[l] + PW'(r_s3_zp);
      if (w_b[l] > Q_MAX) begin
        w_q[l*OUT_W +: OUT_W] = Q_MAX[OUT_W-1:0];
        w_sat[l]              = 1'b1;
      end else if (w_b[l] < Q_MIN) begin
        w_q[l*OUT_W +: OUT_W] = Q_MIN[OUT_W-1:0];
        w_sat[l]              = 1'b1;
      end else begin
        w_q[l*OUT_W +: OUT_W] = w_b[l][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat_flags <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= in_valid;
      r_s2_valid  <= r_s1_valid;
      r_s3_valid  <= r_s2_valid;
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_data  <= w_q;
        r_sat_flags <= w_sat;
      end
    end
  end

  // Datapath registers only load for valid beats; bubbles leave them untouched.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      if (in_valid) begin
        r_s1_y   <= w_y;
        r_s1_inv <= $signed(inv_scale);
        r_s1_zp  <= $signed(zero_point);
      end
      if (r_s1_valid) begin
        for (int unsigned l = 0; l < LANES; l++)
          r_s2_p[l] <= PW'(r_s1_y[l]) * PW'(r_s1_inv);
        r_s2_zp <= r_s1_zp;
      end
      if (r_s2_valid) begin
        for (int unsigned l = 0; l < LANES; l++)
          r_s3_r[l] <= (r_s2_p[l] + ROUND_HALF) >>> FRAC_BITS;
        r_s3_zp <= r_s2_zp;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned l = 0; l < LANES; l++)
      w_pop = w_pop + (CNT_W+1)'(r_sat_flags[l]);
    w_sum = {1'b0, r_sat_count} + w_pop;
  end

  always_ff @(posedge clk) begin
    if (reset || sat_clear)
      r_sat_count <= '0;
    else if (r_out_valid && out_ready)
      r_sat_count <= (w_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_sum[CNT_W-1:0];
  end

endmodule

// File: tb/tb_vec_act_quant_pipe.sv
// Directed self-checking bench for vec_act_quant_pipe: vector table plus backpressure,
// saturation-counter and mid-stream reset sequences. Honours LEAKY_RELU_EN for mode 3 expectations.
module tb_vec_act_quant_pipe;
  localparam int LANES = 4, ACC_W = 32, OUT_W = 8, FRAC_BITS = 8, CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*ACC_W-1:0] in_data;
  logic [1:0]             act_mode;
  logic [ACC_W-1:0]       clip_max;
  logic [4:0]             leak_shift;
  logic [15:0]            inv_scale;
  logic [OUT_W-1:0]       zero_point;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       sat_flags;
  logic [CNT_W-1:0]       sat_count;
  logic                   sat_clear;

  vec_act_quant_pipe #(
    .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .act_mode(act_mode), .clip_max(clip_max), .leak_shift(leak_shift), .inv_scale(inv_scale),
    .zero_point(zero_point), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flags(sat_flags), .sat_count(sat_count), .sat_clear(sat_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]   mode;
    logic [31:0]  clip;
    logic [4:0]   leak;
    logic [15:0]  inv;
    logic [7:0]   zp;
    logic [127:0] x;
    logic [31:0]  q;
    logic [3:0]   fl;
  } vec_t;

  function automatic vec_t mk(input int mode, input int clip, input int leak, input int inv,
                              input int zp, input int x0, input int x1, input int x2, input int x3,
                              input int q0, input int q1, input int q2, input int q3, input int fl);
    vec_t v;
    v.mode = 2'(mode);
    v.clip = 32'(clip);
    v.leak = 5'(leak);
    v.inv  = 16'(inv);
    v.zp   = 8'(zp);
    v.x    = {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
    v.q    = {8'(q3), 8'(q2), 8'(q1), 8'(q0)};
    v.fl   = 4'(fl);
    return v;
  endfunction

  task automatic set_cfg(input int mode, input int inv, input int zp);
    act_mode   = 2'(mode);
    clip_max   = '0;
    leak_shift = '0;
    inv_scale  = 16'(inv);
    zero_point = 8'(zp);
  endtask

  // One beat; config is scrambled right after acceptance to prove it travels with the beat.
  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    string n;
    n = $sformatf("vec%0d", idx);
    @(negedge clk);
    act_mode = v.mode; clip_max = v.clip; leak_shift = v.leak;
    inv_scale = v.inv; zero_point = v.zp; in_data = v.x; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; act_mode = 2'd0; clip_max = '0; inv_scale = 16'h0000;
    zero_point = 8'h55; leak_shift = 5'd7; in_data = '1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({n, " latency"}, 64'(lat), 64'd4);
    check({n, " data"}, 64'(out_data), 64'(v.q));
    check({n, " flags"}, 64'(sat_flags), 64'(v.fl));
  endtask

  task automatic stream(input int n, input int x0, input int x1, input int x2, input int x3);
    @(negedge clk);
    set_cfg(0, 'h100, 0);
    in_data  = {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
    in_valid = 1'b1;
    repeat (n - 1) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] bp_lanes(input int b);
    logic [31:0] r;
    for (int l = 0; l < LANES; l++) r[l*8 +: 8] = 8'(b*10 + l*3 - 20);
    return r;
  endfunction

  function automatic logic [127:0] bp_in(input int b);
    logic [127:0] r;
    for (int l = 0; l < LANES; l++) r[l*32 +: 32] = 32'(b*10 + l*3 - 20);
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   sent, rcv, stall_left, cyc, extra, n;
    bit   stalled;

    vt.push_back(mk(1, 0, 0, 'h100, 0,    -5, 0, 100, 300,     0, 0, 100, 127,   4'b1000));
    vt.push_back(mk(0, 0, 0, 'h080, 0,    3, -3, 5, 255,       2, -1, 3, 127,    4'b1000));
    vt.push_back(mk(0, 0, 0, 'h100, -10,  -120, -118, 0, 137,  -128, -128, -10, 127, 4'b0001));
    vt.push_back(mk(2, 6, 0, 'h100, 0,    -1, 3, 6, 50,        0, 3, 6, 6,       4'b0000));
    vt.push_back(mk(2, -5, 0, 'h100, 0,   10, -3, 0, 1000,     0, 0, 0, 0,       4'b0000));
    vt.push_back(mk(0, 0, 0, 'hFF00, 5,   10, -10, 200, -200,  -5, 15, -128, 127, 4'b1100));
    vt.push_back(mk(0, 0, 0, 'h080, 0,    -1, -2, 1, 0,        0, -1, 1, 0,      4'b0000));
    vt.push_back(mk(0, 0, 0, 'h7FFF, 0,   -2147483647 - 1, 2147483647, 1, -1,
                    -128, 127, 127, -128, 4'b0111));
    vt.push_back(mk(1, 0, 0, 'h100, 127,  -5, 1, 0, -1000,     127, 127, 127, 127, 4'b0010));
`ifdef LEAKY_RELU_EN
    vt.push_back(mk(3, 0, 3, 'h100, 0,    -80, 40, -1, 7,      -10, 40, -1, 7,   4'b0000));
    vt.push_back(mk(3, 0, 0, 'h100, 0,    -50, -128, -129, 5,  -50, -128, -128, 5, 4'b0100));
`else
    vt.push_back(mk(3, 0, 3, 'h100, 0,    -80, 40, -1, 7,      0, 40, 0, 7,      4'b0000));
    vt.push_back(mk(3, 0, 0, 'h100, 0,    -50, -128, -129, 5,  0, 0, 0, 5,       4'b0000));
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
    in_data = '0; set_cfg(0, 'h100, 0);
    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset sat_flags", 64'(sat_flags), 64'd0);
    check("reset sat_count", 64'(sat_count), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) run_vec(i, vt[i]);

    // Backpressure: 8 back-to-back beats, output held for 3 cycles while beat 2 is presented.
    sent = 0; rcv = 0; stall_left = 0; cyc = 0; stalled = 1'b0;
    while (rcv < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (out_valid && rcv == 2 && !stalled) begin
        stalled    = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      if (sent < 8) begin
        set_cfg(0, 'h100, 0);
        in_data  = bp_in(sent);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        stall_left--;
        check("bp stall in_ready", 64'(in_ready), 64'd0);
        check("bp stall out_valid", 64'(out_valid), 64'd1);
        check("bp stall out_data held", 64'(out_data), 64'(bp_lanes(2)));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("bp beat%0d data", rcv), 64'(out_data), 64'(bp_lanes(rcv)));
        rcv++;
      end
    end
    check("bp beats delivered", 64'(rcv), 64'd8);
    check("bp stall happened", 64'(stalled), 64'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("bp no extra beats", 64'(extra), 64'd0);

    // Saturation counter.
    @(negedge clk); sat_clear = 1'b1;
    @(negedge clk); sat_clear = 1'b0;
    check("sat_count cleared", 64'(sat_count), 64'd0);
    stream(1, 200, 200, -200, 0);
    stream(1, 200, 200, -200, 0);
    check("sat_count two beats", 64'(sat_count), 64'd6);
    @(negedge clk);
    set_cfg(0, 'h100, 0);
    in_data  = {32'd0, 32'd0, -32'sd200, 32'sd200};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("clear beat at output", 64'(out_valid), 64'd1);
    check("clear beat flags", 64'(sat_flags), 64'b0011);
    sat_clear = 1'b1;
    @(negedge clk);
    sat_clear = 1'b0;
    check("sat_clear priority", 64'(sat_count), 64'd0);
    check("clear beat consumed", 64'(out_valid), 64'd0);
    stream(16383, 200, 200, 200, 200);
    check("sat_count preload", 64'(sat_count), 64'd65532);
    stream(1, 200, -200, 0, 0);
    check("sat_count near max", 64'(sat_count), 64'd65534);
    stream(1, 200, 200, -200, 0);
    check("sat_count saturates", 64'(sat_count), 64'hFFFF);
    stream(1, 200, 200, -200, 0);
    check("sat_count holds max", 64'(sat_count), 64'hFFFF);

    // Reset with three beats in flight.
    @(negedge clk);
    set_cfg(0, 'h100, 0);
    in_data  = {32'sd200, 32'sd200, 32'sd200, 32'sd200};
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset sat_count", 64'(sat_count), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    check("midreset out_data", 64'(out_data), 64'd0);
    check("midreset sat_flags", 64'(sat_flags), 64'd0);
    reset = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("midreset no stale beat", 64'(extra), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
